// File: rtl/xalloc_pkg.sv
// Shared buffer-ID allocator definitions used across switch stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xalloc_pkg;

    localparam int XA_DEPTH = 8;
    localparam int XA_AW    = $clog2(XA_DEPTH);

    typedef logic [XA_AW-1:0] id_t;

endpackage

// File: rtl/xalloc_xcc.sv
// Circular-list pointer pair with overflow bits, registered not-empty flag and length.
// Latency: pointers and empty_n update at the edge after re/we.
// Backpressure: reads are ignored while empty, writes are ignored while full.
module xalloc_xcc
    import xalloc_pkg::*;
#(
    parameter int LENGTH    = XA_DEPTH,
    parameter bit INIT_FULL = 1'b1,
    localparam int AW       = $clog2(LENGTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          re,
    input  logic          we,
    output logic [AW-1:0] rptr,
    output logic [AW-1:0] wptr,
    output logic          empty_n,
    output logic [AW:0]   length
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(LENGTH);
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] INIT_W   = INIT_FULL ? FULL_CNT : '0;

    logic [AW:0] rcnt, wcnt;
    logic [AW:0] rcnt_nx, wcnt_nx;
    logic        do_rd, do_wr;

    assign length = wcnt - rcnt;
    assign rptr   = rcnt[AW-1:0];
    assign wptr   = wcnt[AW-1:0];

    assign do_rd   = re & empty_n;
    assign do_wr   = we & (length != FULL_CNT);
    assign rcnt_nx = do_rd ? rcnt + ONE : rcnt;
    assign wcnt_nx = do_wr ? wcnt + ONE : wcnt;

    // Overflow bit makes full and empty distinguishable when pointers match.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rcnt    <= '0;
            wcnt    <= INIT_W;
            empty_n <= INIT_FULL;
        end else begin
            rcnt    <= rcnt_nx;
            wcnt    <= wcnt_nx;
            empty_n <= (wcnt_nx - rcnt_nx) != '0;
        end
    end

endmodule

// File: rtl/xalloc.sv
// Buffer-ID allocator: free-ID circular list plus in-use bitmap with double-free detection.
// Latency: grant is combinational (0 cycles); frees become grantable the next cycle.
// Backpressure: alloc_req is not granted while avail_n is low; illegal frees are dropped and flagged.
module xalloc
    import xalloc_pkg::*;
#(
    parameter int DEPTH = XA_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          alloc_req,
    output logic          alloc_gnt,
    output logic [AW-1:0] alloc_id,
    input  logic          free_vld,
    input  logic [AW-1:0] free_id,
    output logic          avail_n,
    output logic [AW:0]   free_cnt,
    output logic          err_dfree,
    output logic [AW-1:0] err_id
);

    logic [AW-1:0]    fl [DEPTH];
    logic [DEPTH-1:0] inuse, inuse_nx;
    logic [AW-1:0]    rptr, wptr;
    logic             free_ok;

    xalloc_xcc #(
        .LENGTH    (DEPTH),
        .INIT_FULL (1'b1)
    ) u_xcc (
        .clk     (clk),
        .rstn    (rstn),
        .re      (alloc_req),
        .we      (free_ok),
        .rptr    (rptr),
        .wptr    (wptr),
        .empty_n (avail_n),
        .length  (free_cnt)
    );

    assign alloc_gnt = alloc_req & avail_n;
    assign alloc_id  = fl[rptr];
    // An ID granted this cycle still reads as not-in-use, so freeing it is illegal.
    assign free_ok   = free_vld & inuse[free_id];

    always_comb begin
        inuse_nx = inuse;
        if (alloc_gnt) inuse_nx[alloc_id] = 1'b1;
        if (free_ok)   inuse_nx[free_id]  = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) fl[i] <= AW'(i);
            inuse     <= '0;
            err_dfree <= 1'b0;
            err_id    <= '0;
        end else begin
            if (free_ok) fl[wptr] <= free_id;
            inuse     <= inuse_nx;
            err_dfree <= free_vld & ~inuse[free_id];
            if (free_vld & ~inuse[free_id]) err_id <= free_id;
        end
    end

endmodule

// File: tb/tb_xalloc.sv
// Scoreboard bench for xalloc at DEPTH=4: directed stimulus pushes expected grants/errors,
// a negedge monitor pops and compares whenever the DUT presents a grant or error pulse.
module tb_xalloc;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [AW-1:0] alloc_id;
    logic          free_vld;
    logic [AW-1:0] free_id;
    logic          avail_n;
    logic [AW:0]   free_cnt;
    logic          err_dfree;
    logic [AW-1:0] err_id;

    int checks   = 0;
    int failures = 0;

    int gnt_q[$];
    int err_q[$];

    xalloc #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_id  (alloc_id),
        .free_vld  (free_vld),
        .free_id   (free_id),
        .avail_n   (avail_n),
        .free_cnt  (free_cnt),
        .err_dfree (err_dfree),
        .err_id    (err_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; returns #1 after the committing edge.
    task automatic cyc(input logic r, input logic fv, input int fid);
        alloc_req = r;
        free_vld  = fv;
        free_id   = AW'(fid);
        @(posedge clk);
        #1;
        alloc_req = 1'b0;
        free_vld  = 1'b0;
        free_id   = '0;
    endtask

    // Monitor: every presented grant or error pulse must match the next expected entry.
    always @(negedge clk) begin
        if (rstn && alloc_gnt) begin
            if (gnt_q.size() == 0) chk("unexpected_grant_id", int'(alloc_id), -1);
            else chk("grant_id", int'(alloc_id), gnt_q.pop_front());
        end
        if (rstn && err_dfree) begin
            if (err_q.size() == 0) chk("unexpected_err_dfree", int'(err_id), -1);
            else chk("err_id", int'(err_id), err_q.pop_front());
        end
    end

    initial begin
        rstn      = 1'b0;
        alloc_req = 1'b0;
        free_vld  = 1'b0;
        free_id   = '0;
        @(posedge clk);
        #1;
        chk("reset_free_cnt", int'(free_cnt), 4);
        chk("reset_avail_n", int'(avail_n), 1);
        chk("reset_err_dfree", int'(err_dfree), 0);
        chk("reset_err_id", int'(err_id), 0);
        chk("reset_gnt", int'(alloc_gnt), 0);
        rstn = 1'b1;

        // Drain the pool; the fifth request must not be granted.
        for (int i = 0; i < 4; i++) begin
            gnt_q.push_back(i);
            cyc(1'b1, 1'b0, 0);
        end
        chk("drain_free_cnt", int'(free_cnt), 0);
        chk("drain_avail_n", int'(avail_n), 0);
        cyc(1'b1, 1'b0, 0);
        chk("empty_req_free_cnt", int'(free_cnt), 0);

        // Free 2 then 0, regrant in that order.
        cyc(1'b0, 1'b1, 2);
        chk("free2_cnt", int'(free_cnt), 1);
        cyc(1'b0, 1'b1, 0);
        chk("free0_cnt", int'(free_cnt), 2);
        gnt_q.push_back(2);
        cyc(1'b1, 1'b0, 0);
        chk("regrant2_cnt", int'(free_cnt), 1);
        gnt_q.push_back(0);
        cyc(1'b1, 1'b0, 0);
        chk("regrant0_cnt", int'(free_cnt), 0);

        // Empty pool: same-cycle request and free withholds the grant.
        cyc(1'b1, 1'b1, 1);
        chk("empty_simul_cnt", int'(free_cnt), 1);
        chk("empty_simul_avail", int'(avail_n), 1);
        gnt_q.push_back(1);
        cyc(1'b1, 1'b0, 0);
        chk("late_grant_cnt", int'(free_cnt), 0);

        // Freeing the ID granted in the same cycle is a double free.
        cyc(1'b0, 1'b1, 3);
        gnt_q.push_back(3);
        err_q.push_back(3);
        cyc(1'b1, 1'b1, 3);
        chk("same_id_dfree_cnt", int'(free_cnt), 0);
        cyc(1'b0, 1'b0, 0);

        // Two allocated: simultaneous grant/free keeps the count, wrap keeps order.
        cyc(1'b0, 1'b1, 0);
        cyc(1'b0, 1'b1, 1);
        chk("two_free_cnt", int'(free_cnt), 2);
        gnt_q.push_back(0);
        cyc(1'b1, 1'b1, 2);
        chk("simul_cnt_a", int'(free_cnt), 2);
        gnt_q.push_back(1);
        cyc(1'b1, 1'b1, 3);
        chk("simul_cnt_b", int'(free_cnt), 2);
        gnt_q.push_back(2);
        cyc(1'b1, 1'b1, 0);
        chk("simul_cnt_c", int'(free_cnt), 2);
        gnt_q.push_back(3);
        cyc(1'b1, 1'b0, 0);
        gnt_q.push_back(0);
        cyc(1'b1, 1'b0, 0);
        chk("wrap_drain_cnt", int'(free_cnt), 0);
        chk("wrap_drain_avail", int'(avail_n), 0);

        // Mid-operation reset with three IDs outstanding.
        cyc(1'b0, 1'b1, 0);
        chk("pre_reset_cnt", int'(free_cnt), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset_cnt", int'(free_cnt), 4);
        chk("async_reset_avail", int'(avail_n), 1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        gnt_q.push_back(0);
        cyc(1'b1, 1'b0, 0);
        chk("post_reset_cnt", int'(free_cnt), 3);

        // Never-allocated free right after reset.
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        err_q.push_back(3);
        cyc(1'b0, 1'b1, 3);
        chk("dfree_pulse", int'(err_dfree), 1);
        chk("dfree_cnt", int'(free_cnt), 4);
        cyc(1'b0, 1'b0, 0);
        chk("dfree_one_cycle", int'(err_dfree), 0);
        chk("dfree_err_id_hold", int'(err_id), 3);

        cyc(1'b0, 1'b0, 0);
        chk("gnt_q_drained", gnt_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
